// File: rtl/booth_acc.sv
// booth_acc: saturating frame accumulator behind booth_multi.
// Sums N_TERMS signed products per frame, then holds the total on a
// valid/ready handshake until the consumer takes it.
module booth_acc #(
    parameter int PROD_W  = 8,
    parameter int ACC_W   = 12,
    parameter int N_TERMS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [PROD_W-1:0] prod,
    input  logic                     prod_done,
    input  logic                     clear,
    output logic                     ready_in,
    output logic signed [ACC_W-1:0]  acc_out,
    output logic                     acc_valid,
    input  logic                     acc_ready,
    output logic [7:0]               term_cnt,
    output logic                     ovf,
    output logic                     drop_err
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(N_TERMS);

    // Saturation bounds expressed in the one-bit-wider sum domain.
    localparam logic signed [ACC_W:0] SUM_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SUM_MIN = {2'b11, {(ACC_W-1){1'b0}}};

    // Clamp a wide sum into the accumulator range.
    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] s);
        logic signed [ACC_W-1:0] r;
        if (s > SUM_MAX)
            r = SUM_MAX[ACC_W-1:0];
        else if (s < SUM_MIN)
            r = SUM_MIN[ACC_W-1:0];
        else
            r = s[ACC_W-1:0];
        return r;
    endfunction

    // True when sat_acc would clip the sum.
    function automatic logic sat_clipped(input logic signed [ACC_W:0] s);
        return (s > SUM_MAX) || (s < SUM_MIN);
    endfunction

    state_t                  state, state_nx;
    logic signed [ACC_W-1:0] acc, acc_nx;
    logic [7:0]              cnt_nx;
    logic                    ovf_nx, drop_nx;
    logic                    done_q;
    logic                    prod_evt;
    logic signed [ACC_W:0]   acc_ext, prod_ext, sum;

    assign prod_evt  = prod_done & ~done_q;
    assign ready_in  = (state == ACCUM);
    assign acc_valid = (state == HOLD);
    assign acc_out   = acc;

    // Next-state and next-datapath decode; clear outranks everything but reset.
    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        cnt_nx   = term_cnt;
        ovf_nx   = ovf;
        drop_nx  = drop_err;
        acc_ext  = {acc[ACC_W-1], acc};
        prod_ext = {{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod};
        sum      = acc_ext + prod_ext;

        if (clear) begin
            state_nx = ACCUM;
            acc_nx   = '0;
            cnt_nx   = '0;
            ovf_nx   = 1'b0;
            drop_nx  = 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (prod_evt) begin
                        acc_nx = sat_acc(sum);
                        ovf_nx = ovf | sat_clipped(sum);
                        cnt_nx = term_cnt + 8'd1;
                        if (term_cnt + 8'd1 == CNT_LAST)
                            state_nx = HOLD;
                    end
                end
                HOLD: begin
                    // A product arriving while the total is pending is lost.
                    if (prod_evt)
                        drop_nx = 1'b1;
                    if (acc_ready) begin
                        state_nx = ACCUM;
                        acc_nx   = '0;
                        cnt_nx   = '0;
                        ovf_nx   = 1'b0;
                    end
                end
                default: state_nx = ACCUM;
            endcase
        end
    end

    // State, accumulator, flags and done edge detector.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ACCUM;
            acc      <= '0;
            term_cnt <= '0;
            ovf      <= 1'b0;
            drop_err <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            acc      <= acc_nx;
            term_cnt <= cnt_nx;
            ovf      <= ovf_nx;
            drop_err <= drop_nx;
            done_q   <= prod_done;
        end
    end

endmodule

// File: doc/booth_acc.md
# booth_acc

Downstream accumulator stage for `booth_multi`. Captures each signed product when the multiplier's `done` rises, sums a fixed-length frame of `N_TERMS` products into a wide saturating accumulator, and presents the frame total to the consumer over a valid/ready handshake. It turns the single-product multiplier into a dot-product / MAC datapath.

## Interface
- `PROD_W`, 8: width of the signed product from `booth_multi` (`res`).
- `ACC_W`, 12: width of the signed accumulator and result. Must be ≥ `PROD_W`.
- `N_TERMS`, 4: number of products per frame. Range 1..255.

- `clk`  in  1  rising-edge clock, the only clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `prod`  in  PROD_W  signed product; connects to multiplier `res`.
- `prod_done`  in  1  connects to multiplier `done`. May be a one-cycle pulse or held level.
- `clear`  in  1  synchronous frame abort. Zeroes the accumulator, count and flags; returns to ACCUM.
- `ready_in`  out  1  high when a product will be accepted. Gates the upstream `start`.
- `acc_out`  out  ACC_W  signed frame total; stable while `acc_valid` is high.
- `acc_valid`  out  1  frame total available.
- `acc_ready`  in  1  consumer accepts the total.
- `term_cnt`  out  8  products accumulated in the current frame.
- `ovf`  out  1  sticky: saturation occurred in the current frame.
- `drop_err`  out  1  sticky: a product arrived while `ready_in` was 0.

## Operation
- Edge detect:
  - `prod_done` is registered as `done_q`.
  - An event is `prod_done & ~done_q`.
  - A held `done` therefore counts once. A new event needs `done` to fall and rise again.
- States:
  - ACCUM: `ready_in`=1, `acc_valid`=0.
  - HOLD: `ready_in`=0, `acc_valid`=1.
- ACCUM, on an event:
  - `prod` is sign-extended to ACC_W+1 bits and added to `acc`.
  - The result is saturated to the ACC_W signed range (max 2^(ACC_W-1)-1, min -2^(ACC_W-1)).
  - `ovf` is set if the saturation clipped.
  - `term_cnt` is incremented.
  - When the increment reaches `N_TERMS`, the next state is HOLD.
- HOLD:
  - `acc_out` = `acc`.
  - On `acc_valid & acc_ready`: go to ACCUM, and clear `acc`, `term_cnt` and `ovf`.
- Dropped products:
  - An event in HOLD is dropped. It sets `drop_err`.
  - `drop_err` is cleared only by `clear` or reset.
- Priority, highest first: `rst_n`=0, then `clear`, then handshake/accumulate.
  - `clear` in HOLD discards the pending total without a handshake.
  - An event in the same cycle as `clear` is discarded and does not set `drop_err`.
- Saturation is sticky within a frame. Later products add to the saturated value; no wrap-around ever occurs.

## Timing
- Reset values (cycle after a `rst_n`=0 edge):
  - state ACCUM, `acc`=0, `acc_out`=0, `term_cnt`=0.
  - `acc_valid`=0, `ready_in`=1, `ovf`=0, `drop_err`=0, `done_q`=0.
- `rst_n` low mid-frame aborts immediately; no partial total is emitted.
- Latency:
  - `prod_done` rises at edge t (seen at the t+1 sampling edge).
  - `acc` and `term_cnt` update at edge t+1.
  - On the Nth event, `acc_valid` is high after edge t+1, with the final (saturated) sum already on `acc_out`.
- Handshake:
  - Transfer occurs on the rising edge where `acc_valid` and `acc_ready` are both 1.
  - `acc_valid` drops and `ready_in` rises after that edge.
  - `acc_ready` may be held high permanently; HOLD then lasts exactly one cycle.
  - `acc_out` is unchanged while `acc_valid`=1 and `acc_ready`=0.
- Combinational paths: all outputs are registered or state-decoded. There is no combinational path from `acc_ready` or `prod_done` to any output.
- `N_TERMS`=1: every accepted product produces a total one cycle later.

## Test plan
- **Dot product.** Defaults. Four products via the multiplier: 5×-6=-30, -3×-2=6, -7×-1=7, -3×-7=21, with `acc_ready`=1.
  - Expect `acc_out`=4, `acc_valid` for one cycle, `ovf`=0.
  - Expect `term_cnt` to step 1,2,3,4 and then return to 0.
- **Held done.** `prod_done` held high for 20 cycles with `prod`=-30.
  - Expect exactly one accumulation: `term_cnt`=1, `acc`=-30.
- **Saturation.** `ACC_W`=8, `N_TERMS`=4, four products of 64 (-8×-8).
  - Expect `acc_out`=127 and `ovf`=1.
  - Repeat with -56 (7×-8): expect -128 and `ovf`=1.
- **Back-pressure / drop.** Frame total 4 with `acc_ready`=0 for 10 cycles, plus a product event during HOLD.
  - Expect `acc_out` stable at 4 and `drop_err`=1.
  - After `acc_ready`=1: next frame starts from 0 and `drop_err` stays 1 until `clear`.
- **Clear / reset mid-frame.**
  - After two products (-30, 6), pulse `clear`: expect `acc`=0, `term_cnt`=0, and no `acc_valid`.
  - Same sequence with `rst_n`=0 for one cycle: expect all reset values.
- **Clear vs event collision.** `clear` in the same cycle as a product event.
  - Expect the event discarded, `acc`=0, `term_cnt`=0, `drop_err`=0.
